banked_sram_pipe: RTL and testbench

- Parametrised successor to the team's 256x4b banked single-port SRAM, which is the MBIST target.
- Configurable depth, width and bank count, per-bit write mask, selectable write-port output mode, registered read data with a valid strobe, and a built-in clear engine that sweeps every address.
- Sits under the MBIST controller as the memory under test; the clear engine gives the controller a known background before a march sequence.

---
 rtl/banked_sram_pipe_if.sv | 27 ++
 rtl/banked_sram_pipe.sv | 153 +++++++++++++++
 tb/tb_banked_sram_pipe.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/banked_sram_pipe_if.sv
// rtl/banked_sram_pipe_if.sv - request/response bundle between the MBIST controller and banked_sram_pipe
interface banked_sram_pipe_if #(
  parameter int WCOUNT  = 256,
  parameter int WLENGTH = 4
);
  localparam int AW = $clog2(WCOUNT);

  logic               en;
  logic               we;
  logic [AW-1:0]      addr;
  logic [WLENGTH-1:0] datain;
  logic [WLENGTH-1:0] wmask;
  logic               clr_req;
  logic [WLENGTH-1:0] dataout;
  logic               rd_valid;
  logic               busy;

  modport master (
    output en, we, addr, datain, wmask, clr_req,
    input  dataout, rd_valid, busy
  );

  modport slave (
    input  en, we, addr, datain, wmask, clr_req,
    output dataout, rd_valid, busy
  );
endinterface

// File: rtl/banked_sram_pipe.sv
// rtl/banked_sram_pipe.sv - pipelined banked single-port SRAM with per-bit write mask and clear sweep
module banked_sram_pipe #(
  parameter int                 WCOUNT     = 256,
  parameter int                 WLENGTH    = 4,
  parameter int                 NBANKS     = 8,
  parameter int                 WRITE_MODE = 0,
  parameter logic [WLENGTH-1:0] CLR_VALUE  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  banked_sram_pipe_if.slave mem_if
);
  localparam int AW   = $clog2(WCOUNT);
  localparam int BKW  = $clog2(NBANKS);
  localparam int ROWS = WCOUNT / NBANKS;
  localparam int BIW  = (BKW > 0) ? BKW : 1;
  localparam int RIW  = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  state_e             state_q, state_d;
  logic [AW-1:0]      cnt_q, cnt_d;

  logic               req_v;
  logic               req_we;
  logic [AW-1:0]      req_addr;
  logic [WLENGTH-1:0] req_data;
  logic [WLENGTH-1:0] req_mask;

  logic               s1_vld_q, s1_we_q;
  logic [AW-1:0]      s1_addr_q;
  logic [WLENGTH-1:0] s1_data_q, s1_mask_q;

  logic [BIW-1:0]     s1_bank;
  logic [RIW-1:0]     s1_row;

  logic [WLENGTH-1:0] mem_q [NBANKS][ROWS];
  logic [WLENGTH-1:0] old_word, new_word;

  logic [WLENGTH-1:0] dout_q, dout_d;
  logic               rd_valid_q, rd_valid_d;

  // The clear engine owns S1 while sweeping; the clr_req cycle itself issues nothing.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_v    = 1'b0;
    req_we   = mem_if.we;
    req_addr = mem_if.addr;
    req_data = mem_if.datain;
    req_mask = mem_if.wmask;
    case (state_q)
      ST_IDLE: begin
        if (mem_if.clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else begin
          req_v = mem_if.en;
        end
      end
      ST_CLEAR: begin
        req_v    = 1'b1;
        req_we   = 1'b1;
        req_addr = cnt_q;
        req_data = CLR_VALUE;
        req_mask = '1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == AW'(WCOUNT - 1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_we_q   <= 1'b0;
      s1_addr_q <= '0;
      s1_data_q <= '0;
      s1_mask_q <= '0;
    end else begin
      s1_vld_q  <= req_v;
      s1_we_q   <= req_we;
      s1_addr_q <= req_addr;
      s1_data_q <= req_data;
      s1_mask_q <= req_mask;
    end
  end

  // Bank is the top address field, row the remainder.
  generate
    if (NBANKS > 1) begin : g_bank
      assign s1_bank = s1_addr_q[AW-1 -: BKW];
    end else begin : g_nobank
      assign s1_bank = '0;
    end
    if (ROWS > 1) begin : g_row
      assign s1_row = s1_addr_q[AW-BKW-1:0];
    end else begin : g_norow
      assign s1_row = '0;
    end
  endgenerate

  assign old_word = mem_q[s1_bank][s1_row];
  assign new_word = (old_word & ~s1_mask_q) | (s1_data_q & s1_mask_q);

  // No reset on the array; s1_vld_q clears asynchronously so nothing commits after reset.
  always_ff @(posedge clk) begin
    if (s1_vld_q && s1_we_q) begin
      mem_q[s1_bank][s1_row] <= new_word;
    end
  end

  always_comb begin
    dout_d     = dout_q;
    rd_valid_d = s1_vld_q && !s1_we_q;
    if (s1_vld_q) begin
      if (!s1_we_q) begin
        dout_d = old_word;
      end else if (WRITE_MODE == 1) begin
        dout_d = new_word;
      end else if (WRITE_MODE == 2) begin
        dout_d = old_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      dout_q     <= dout_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign mem_if.dataout  = dout_q;
  assign mem_if.rd_valid = rd_valid_q;
  assign mem_if.busy     = (state_q == ST_CLEAR);
endmodule

// File: tb/tb_banked_sram_pipe.sv
// tb/tb_banked_sram_pipe.sv - scoreboard bench: 256x4 default instance plus 64x8 bank/write-mode sweep
module tb_banked_sram_pipe;
  localparam int NL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_a, rst_n_s;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_errors = 0;
  bit   finish_req = 1'b0;

  logic       a_en, a_we, a_clr, s_en, s_we;
  logic [7:0] a_addr, a_din, a_mask, s_addr, s_din, s_mask;

  logic [7:0] lane_dout [NL];
  logic       lane_rv   [NL];
  logic       lane_busy [NL];

  // Lane 0: 256x4, 8 banks, hold mode.
  banked_sram_pipe_if #(.WCOUNT(256), .WLENGTH(4)) bus_a ();
  assign bus_a.en      = a_en;
  assign bus_a.we      = a_we;
  assign bus_a.addr    = a_addr;
  assign bus_a.datain  = a_din[3:0];
  assign bus_a.wmask   = a_mask[3:0];
  assign bus_a.clr_req = a_clr;

  banked_sram_pipe #(.WCOUNT(256), .WLENGTH(4), .NBANKS(8), .WRITE_MODE(0), .CLR_VALUE(4'h0)) dut_a (
    .clk    (clk),
    .rst_n  (rst_n_a),
    .mem_if (bus_a.slave)
  );
  assign lane_dout[0] = {4'h0, bus_a.dataout};
  assign lane_rv[0]   = bus_a.rd_valid;
  assign lane_busy[0] = bus_a.busy;

  // Lanes 1..3: 64x8 with NBANKS 1/2/16 and WRITE_MODE 1/2/0, all fed the same stimulus.
  for (genvar g = 1; g < NL; g++) begin : g_sw
    localparam int NB = (g == 1) ? 1 : (g == 2) ? 2 : 16;
    localparam int WM = (g == 1) ? 1 : (g == 2) ? 2 : 0;
    banked_sram_pipe_if #(.WCOUNT(64), .WLENGTH(8)) bus ();
    assign bus.en      = s_en;
    assign bus.we      = s_we;
    assign bus.addr    = s_addr[5:0];
    assign bus.datain  = s_din;
    assign bus.wmask   = s_mask;
    assign bus.clr_req = 1'b0;
    banked_sram_pipe #(.WCOUNT(64), .WLENGTH(8), .NBANKS(NB), .WRITE_MODE(WM), .CLR_VALUE(8'h00)) dut (
      .clk    (clk),
      .rst_n  (rst_n_s),
      .mem_if (bus.slave)
    );
    assign lane_dout[g] = bus.dataout;
    assign lane_rv[g]   = bus.rd_valid;
    assign lane_busy[g] = bus.busy;
  end

  typedef struct {
    int         lane;
    int         due;
    bit         rv_c;
    bit         rv;
    logic [7:0] dout;
    logic [7:0] dkn;
    bit         busy_c;
    bit         busy;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: word arrays with known-bit tracking; a write lands one step after issue.
  logic [7:0] m_mem  [NL][256];
  logic [7:0] m_kn   [NL][256];
  logic [7:0] m_dout [NL];
  logic [7:0] m_dkn  [NL];
  bit         pend_v [NL];
  logic [7:0] pend_a [NL], pend_d [NL], pend_m [NL];
  bit         clr_act[NL];
  int         clr_cnt[NL];

  function automatic int l_words(int l);
    return (l == 0) ? 256 : 64;
  endfunction

  function automatic logic [7:0] l_wm(int l);
    return (l == 0) ? 8'h0F : 8'hFF;
  endfunction

  function automatic int l_mode(int l);
    return (l == 1) ? 1 : (l == 2) ? 2 : 0;
  endfunction

  task automatic model_reset(int l);
    exp_t keep[$];
    pend_v[l]  = 1'b0;
    clr_act[l] = 1'b0;
    clr_cnt[l] = 0;
    m_dout[l]  = 8'h00;
    m_dkn[l]   = l_wm(l);
    foreach (sb_q[i]) if (sb_q[i].lane != l) keep.push_back(sb_q[i]);
    sb_q = keep;
  endtask

  task automatic push_reset_check(int l);
    exp_t e;
    e = '{lane: l, due: cyc, rv_c: 1'b1, rv: 1'b0, dout: 8'h00, dkn: 8'hFF, busy_c: 1'b1, busy: 1'b0};
    sb_q.push_back(e);
  endtask

  task automatic model_lane(int l, bit en, bit we, logic [7:0] addr, logic [7:0] d, logic [7:0] m, bit clr);
    exp_t       e;
    bit         req, rwe;
    logic [7:0] a, wm, old, okn, mrg;
    wm = l_wm(l);
    if (pend_v[l]) begin
      m_mem[l][pend_a[l]] = (m_mem[l][pend_a[l]] & ~pend_m[l]) | (pend_d[l] & pend_m[l]);
      m_kn[l][pend_a[l]]  = m_kn[l][pend_a[l]] | pend_m[l];
      pend_v[l] = 1'b0;
    end
    e = '{lane: l, due: cyc, rv_c: 1'b0, rv: 1'b0, dout: 8'h00, dkn: 8'h00, busy_c: 1'b1, busy: clr_act[l]};
    sb_q.push_back(e);
    req = 1'b0;
    rwe = we;
    a   = addr & 8'(l_words(l) - 1);
    m   = m & wm;
    d   = d & wm;
    if (clr_act[l]) begin
      req = 1'b1;
      rwe = 1'b1;
      a   = 8'(clr_cnt[l]);
      d   = 8'h00;
      m   = wm;
      clr_cnt[l]++;
      if (clr_cnt[l] == l_words(l)) clr_act[l] = 1'b0;
    end else if (clr) begin
      clr_act[l] = 1'b1;
      clr_cnt[l] = 0;
    end else begin
      req = en;
    end
    e = '{lane: l, due: cyc + 2, rv_c: 1'b1, rv: 1'b0, dout: 8'h00, dkn: 8'h00, busy_c: 1'b0, busy: 1'b0};
    if (req) begin
      old = m_mem[l][a];
      okn = m_kn[l][a] & wm;
      mrg = (old & ~m) | (d & m);
      if (rwe) begin
        pend_v[l] = 1'b1;
        pend_a[l] = a;
        pend_d[l] = d;
        pend_m[l] = m;
        if (l_mode(l) == 1) begin
          m_dout[l] = mrg;
          m_dkn[l]  = okn | m;
        end else if (l_mode(l) == 2) begin
          m_dout[l] = old;
          m_dkn[l]  = okn;
        end
      end else begin
        e.rv      = 1'b1;
        m_dout[l] = old;
        m_dkn[l]  = okn;
      end
    end
    e.dout = m_dout[l];
    e.dkn  = m_dkn[l] & wm;
    sb_q.push_back(e);
  endtask

  task automatic step();
    model_lane(0, a_en, a_we, a_addr, a_din, a_mask, a_clr);
    for (int l = 1; l < NL; l++) model_lane(l, s_en, s_we, s_addr, s_din, s_mask, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(bit en, bit we, logic [7:0] addr, logic [7:0] d, logic [7:0] m, bit clr);
    s_en = 1'b0; s_we = 1'b0;
    a_en = en; a_we = we; a_addr = addr; a_din = d; a_mask = m; a_clr = clr;
    step();
  endtask

  task automatic drive_s(bit en, bit we, logic [7:0] addr, logic [7:0] d, logic [7:0] m);
    a_en = 1'b0; a_we = 1'b0; a_clr = 1'b0;
    s_en = en; s_we = we; s_addr = addr; s_din = d; s_mask = m;
    step();
  endtask

  always @(negedge clk) begin
    bit   rv_seen [NL];
    exp_t e;
    int   i;
    for (int l = 0; l < NL; l++) rv_seen[l] = 1'b0;
    i = 0;
    while (i < sb_q.size()) begin
      if (sb_q[i].due > cyc) begin
        i++;
      end else begin
        e = sb_q[i];
        sb_q.delete(i);
        if (e.due < cyc) begin
          n_checks++; n_errors++;
          $display("FAIL stale_entry lane%0d: due cycle %0d, now %0d", e.lane, e.due, cyc);
        end else begin
          if (e.rv_c) begin
            rv_seen[e.lane] = 1'b1;
            n_checks++;
            if (lane_rv[e.lane] !== e.rv) begin
              n_errors++;
              $display("FAIL rd_valid lane%0d cyc%0d: got %b want %b", e.lane, cyc, lane_rv[e.lane], e.rv);
            end
          end
          if (e.dkn != 8'h00) begin
            n_checks++;
            if (((lane_dout[e.lane] ^ e.dout) & e.dkn) !== 8'h00) begin
              n_errors++;
              $display("FAIL dataout lane%0d cyc%0d: got %h want %h", e.lane, cyc, lane_dout[e.lane], e.dout);
            end
          end
          if (e.busy_c) begin
            n_checks++;
            if (lane_busy[e.lane] !== e.busy) begin
              n_errors++;
              $display("FAIL busy lane%0d cyc%0d: got %b want %b", e.lane, cyc, lane_busy[e.lane], e.busy);
            end
          end
        end
      end
    end
    for (int l = 0; l < NL; l++) begin
      if (!rv_seen[l] && lane_rv[l] !== 1'b0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_rd_valid lane%0d cyc%0d: got %b want 0", l, cyc, lane_rv[l]);
      end
    end
    if (finish_req) begin
      n_checks++;
      if (sb_q.size() != 0) begin
        n_errors++;
        $display("FAIL drain: %0d expected responses never seen, want 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
    end
  end

  logic [7:0] edge_addr [4] = '{8'h00, 8'h1F, 8'h20, 8'hFF};
  logic [7:0] edge_data [4] = '{8'h0A, 8'h05, 8'h0C, 8'h03};
  logic [7:0] last_sa = 8'h00;

  initial begin
    rst_n_a = 1'b0; rst_n_s = 1'b0;
    a_en = 1'b0; a_we = 1'b0; a_clr = 1'b0; a_addr = '0; a_din = '0; a_mask = '0;
    s_en = 1'b0; s_we = 1'b0; s_addr = '0; s_din = '0; s_mask = '0;
    for (int l = 0; l < NL; l++) for (int w = 0; w < 256; w++) m_kn[l][w] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    for (int l = 0; l < NL; l++) push_reset_check(l);
    @(posedge clk);
    #1;
    rst_n_a = 1'b1; rst_n_s = 1'b1;
    for (int l = 0; l < NL; l++) model_reset(l);

    // Bank-edge writes, readback, partial-mask merge and write-then-read hazard on lane 0.
    for (int i = 0; i < 4; i++) drive_a(1, 1, edge_addr[i], edge_data[i], 8'h0F, 0);
    for (int i = 0; i < 4; i++) drive_a(1, 0, edge_addr[i], 8'h00, 8'h00, 0);
    drive_a(0, 0, 8'h00, 8'h00, 8'h00, 0);
    drive_a(1, 1, 8'h40, 8'h0F, 8'h0F, 0);
    drive_a(1, 1, 8'h40, 8'h00, 8'h05, 0);
    drive_a(1, 0, 8'h40, 8'h00, 8'h00, 0);
    drive_a(1, 1, 8'h40, 8'h00, 8'h00, 0);
    drive_a(1, 0, 8'h40, 8'h00, 8'h00, 0);
    drive_a(1, 1, 8'h10, 8'h06, 8'h0F, 0);
    drive_a(1, 0, 8'h10, 8'h00, 8'h00, 0);
    repeat (2) drive_a(0, 0, 8'h00, 8'h00, 8'h00, 0);

    // Fill with addr[3:0], clear with a colliding read, busy window ignores en, then read back.
    for (int w = 0; w < 256; w++) drive_a(1, 1, 8'(w), 8'(w & 15), 8'h0F, 0);
    drive_a(1, 0, 8'h07, 8'h00, 8'h00, 0);
    drive_a(1, 0, 8'h33, 8'h00, 8'h00, 1);
    for (int c = 0; c < 256; c++) drive_a(1, 1'($urandom_range(1)), 8'($urandom), 8'($urandom), 8'h0F, 0);
    for (int w = 0; w < 256; w++) drive_a(1, 0, 8'(w), 8'h00, 8'h00, 0);

    // Reset in the middle of a sweep leaves a partially cleared array.
    for (int w = 0; w < 256; w++) drive_a(1, 1, 8'(w), 8'h0F, 8'h0F, 0);
    drive_a(1, 0, 8'h05, 8'h00, 8'h00, 0);
    drive_a(0, 0, 8'h00, 8'h00, 8'h00, 1);
    for (int c = 0; c < 100; c++) drive_a(0, 0, 8'h00, 8'h00, 8'h00, 0);
    rst_n_a = 1'b0;
    #1;
    model_reset(0);
    push_reset_check(0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n_a = 1'b1;
    for (int w = 0; w < 256; w++) drive_a(1, 0, 8'(w), 8'h00, 8'h00, 0);

    // Sweep lanes: fill, write-mode hazard pair, then random traffic.
    for (int w = 0; w < 64; w++) drive_s(1, 1, 8'(w), 8'($urandom), 8'hFF);
    drive_s(1, 1, 8'h10, 8'h5A, 8'hFF);
    drive_s(1, 1, 8'h10, 8'h06, 8'hFF);
    drive_s(1, 0, 8'h10, 8'h00, 8'h00);
    drive_s(0, 0, 8'h00, 8'h00, 8'h00);
    for (int c = 0; c < 1500; c++) begin
      logic [7:0] ra, rm;
      ra = ($urandom_range(3) == 0) ? last_sa : 8'($urandom_range(63));
      case ($urandom_range(3))
        0:       rm = 8'hFF;
        1:       rm = 8'h00;
        default: rm = 8'($urandom);
      endcase
      last_sa = ra;
      drive_s(($urandom_range(9) < 8), 1'($urandom_range(1)), ra, 8'($urandom), rm);
    end

    repeat (4) drive_s(0, 0, 8'h00, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    finish_req = 1'b1;
  end
endmodule
